// File: rtl/conv_mac_pkg.sv
// conv_mac_pkg: shared types and helpers for the conv_mac_pipe dot-product engine.
//   sat_e        : saturation classification (in range / above max / below min)
//   beat_flags_t : first/last framing flags carried alongside each beat
//   clog2_f      : elaboration-time ceil(log2)
//   acc_min_w    : minimum accumulator width that cannot overflow one beat's sum
//   sat_class    : classify a wide signed value against a w-bit signed range
package conv_mac_pkg;

  // Widest intermediate the helpers handle; the post-processor works in ACC_W+2 bits.
  localparam int CALC_W = 64;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_e;

  typedef struct packed {
    logic first;
    logic last;
  } beat_flags_t;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // One beat sums N_TAPS full-width products: 2*DATA_W bits plus carry growth.
  function automatic int acc_min_w(input int dw, input int nt);
    return 2 * dw + clog2_f(nt);
  endfunction

  function automatic sat_e sat_class(input logic signed [CALC_W-1:0] v, input int w);
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return SAT_HI;
    else if (v < lo) return SAT_LO;
    else             return SAT_NONE;
  endfunction

endpackage

// File: rtl/mac_postproc.sv
// mac_postproc: combinational result shaping between the accumulator and the
// output register: bias add, optional ReLU, round-half-up arithmetic right
// shift, and signed saturation to OUT_W.
//   acc_i   : accumulated sum (signed, ACC_W)
//   bias_i  : signed bias (ACC_W)
//   shift_i : right-shift amount, 0 = no shift
//   relu_i  : clamp negative values to zero before shifting
//   data_o  : shaped result (signed, OUT_W)
//   sat_o   : result was clipped by saturation
module mac_postproc
  import conv_mac_pkg::*;
#(
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [ACC_W-1:0]   bias_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               relu_i,
  output logic [OUT_W-1:0]   data_o,
  output logic               sat_o
);

  // ACC_W+1 holds acc+bias exactly; one more bit keeps the rounding add from wrapping.
  localparam int RW = ACC_W + 2;

  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [RW-1:0] sum_w;
  logic signed [RW-1:0] relu_w;
  logic signed [RW-1:0] rnd_w;
  logic signed [RW-1:0] shf_w;
  sat_e                 cls_w;

  always_comb begin
    sum_w  = RW'(signed'(acc_i)) + RW'(signed'(bias_i));
    relu_w = (relu_i && sum_w[RW-1]) ? '0 : sum_w;
    rnd_w  = '0;
    shf_w  = relu_w;
    if (shift_i != '0) begin
      // Add half an LSB of the shifted result, then floor: round half up.
      rnd_w = RW'(1) << (shift_i - SHIFT_W'(1));
      shf_w = (relu_w + rnd_w) >>> shift_i;
    end
    cls_w  = sat_class(CALC_W'(shf_w), OUT_W);
    data_o = shf_w[OUT_W-1:0];
    sat_o  = 1'b0;
    unique case (cls_w)
      SAT_HI: begin
        data_o = OUT_MAX;
        sat_o  = 1'b1;
      end
      SAT_LO: begin
        data_o = OUT_MIN;
        sat_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: fully pipelined signed dot-product engine for conv layers.
// Each accepted beat multiplies N_TAPS data/weight pairs (S1), reduces them
// (S2), accumulates across beats framed by first/last (S3), and on the last
// beat shapes and registers the result on a valid/ready output (S4).
//   clk, rst           : clock, asynchronous active-high reset
//   in_vld/in_rdy      : input beat handshake; in_first/in_last frame a result
//   in_data/in_weight  : packed signed operands, tap i at [i*DATA_W +: DATA_W]
//   cfg_bias/shift/relu: result shaping, sampled when S4 loads
//   out_vld/out_rdy    : output handshake; out_data signed result, out_sat clip flag
module conv_mac_pipe
  import conv_mac_pkg::*;
#(
  parameter int N_TAPS  = 9,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic [N_TAPS*DATA_W-1:0] in_data,
  input  logic [N_TAPS*DATA_W-1:0] in_weight,
  input  logic [ACC_W-1:0]         cfg_bias,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic                     cfg_relu,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_sat
);

  localparam int PW        = 2 * DATA_W;
  localparam int ACC_MIN_W = acc_min_w(DATA_W, N_TAPS);

  if (ACC_W < ACC_MIN_W || OUT_W > ACC_W || ACC_W + 2 > CALC_W) begin : g_param_err
    $error("conv_mac_pipe: illegal ACC_W/OUT_W for DATA_W and N_TAPS");
  end

  // Whole pipe advances together; a stalled output freezes every stage.
  logic en;

  logic [N_TAPS-1:0][PW-1:0] prod_d;
  logic [N_TAPS-1:0][PW-1:0] prod_q;
  logic [2:1]                vld_pipe_q;
  beat_flags_t [2:1]         flg_pipe_q;
  logic [ACC_W-1:0]          s2_d;
  logic [ACC_W-1:0]          s2_q;
  logic [ACC_W-1:0]          acc_q;
  logic                      v3_q;
  logic                      out_vld_q;
  logic [OUT_W-1:0]          out_data_q;
  logic                      out_sat_q;
  logic [OUT_W-1:0]          pp_data;
  logic                      pp_sat;

  assign en     = ~out_vld_q | out_rdy;
  assign in_rdy = en;

  // S1 product array: operands sign-extended so the product is full width.
  for (genvar g = 0; g < N_TAPS; g++) begin : g_tap
    logic signed [PW-1:0] d_ext;
    logic signed [PW-1:0] w_ext;
    assign d_ext     = PW'(signed'(in_data[g*DATA_W +: DATA_W]));
    assign w_ext     = PW'(signed'(in_weight[g*DATA_W +: DATA_W]));
    assign prod_d[g] = d_ext * w_ext;
  end

  // S2 reduction; each product is sign-extended to ACC_W before summing.
  always_comb begin
    s2_d = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      s2_d = s2_d + ACC_W'(signed'(prod_q[i]));
    end
  end

  mac_postproc #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_post (
    .acc_i   (acc_q),
    .bias_i  (cfg_bias),
    .shift_i (cfg_shift),
    .relu_i  (cfg_relu),
    .data_o  (pp_data),
    .sat_o   (pp_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q     <= '0;
      vld_pipe_q <= '0;
      flg_pipe_q <= '0;
      s2_q       <= '0;
      acc_q      <= '0;
      v3_q       <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else if (en) begin
      // S1: in_rdy equals en here, so in_vld alone marks an accepted beat.
      prod_q              <= prod_d;
      vld_pipe_q[1]       <= in_vld;
      flg_pipe_q[1].first <= in_first;
      flg_pipe_q[1].last  <= in_last;
      // S2
      vld_pipe_q[2]       <= vld_pipe_q[1];
      flg_pipe_q[2]       <= flg_pipe_q[1];
      s2_q                <= s2_d;
      // S3: first restarts the sum, dropping any open partial; wraps mod 2^ACC_W.
      if (vld_pipe_q[2]) begin
        acc_q <= flg_pipe_q[2].first ? s2_q : acc_q + s2_q;
      end
      v3_q                <= vld_pipe_q[2] & flg_pipe_q[2].last;
      // S4: data/sat only move when a finished result arrives.
      out_vld_q           <= v3_q;
      if (v3_q) begin
        out_data_q <= pp_data;
        out_sat_q  <= pp_sat;
      end
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_sat  = out_sat_q;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// tb_conv_mac_pipe: randomized and directed stimulus for conv_mac_pipe with a
// frame-level reference model (integer dot products, queue of finished sums,
// result shaping with the configuration present when the result is loaded).
module tb_conv_mac_pipe;

  localparam int N_TAPS  = 9;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 24;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;
  localparam int VW      = N_TAPS * DATA_W;

  logic               clk;
  logic               rst;
  logic               in_vld;
  logic               in_rdy;
  logic               in_first;
  logic               in_last;
  logic [VW-1:0]      in_data;
  logic [VW-1:0]      in_weight;
  logic [ACC_W-1:0]   cfg_bias;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               cfg_relu;
  logic               out_vld;
  logic               out_rdy;
  logic [OUT_W-1:0]   out_data;
  logic               out_sat;

  conv_mac_pipe #(
    .N_TAPS(N_TAPS), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_first(in_first), .in_last(in_last), .in_data(in_data), .in_weight(in_weight),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int data; bit sat; int cyc; } log_t;
  log_t   log_q[$];
  longint raw_q[$];
  longint acc_m = 0;
  bit     held = 0;
  int     held_data;
  bit     held_sat;
  longint bias_prev = 0;
  int     shift_prev = 0;
  bit     relu_prev = 0;

  function automatic longint wrap_acc(longint x);
    logic [ACC_W-1:0] t;
    t = x[ACC_W-1:0];
    return longint'(signed'(t));
  endfunction

  function automatic longint dot(input logic [VW-1:0] d, input logic [VW-1:0] w);
    longint s = 0;
    for (int i = 0; i < N_TAPS; i++)
      s += longint'(signed'(d[i*DATA_W +: DATA_W])) * longint'(signed'(w[i*DATA_W +: DATA_W]));
    return s;
  endfunction

  task automatic shape(input longint acc, input longint bias, input int shift, input bit relu,
                       output int d, output bit s);
    longint r, hi, lo;
    r = acc + bias;
    if (relu && r < 0) r = 0;
    if (shift > 0) r = (r + (longint'(1) <<< (shift - 1))) >>> shift;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -(longint'(1) <<< (OUT_W - 1));
    s = 1'b1;
    if (r > hi)      d = int'(hi);
    else if (r < lo) d = int'(lo);
    else begin d = int'(r); s = 1'b0; end
  endtask

  always @(negedge clk) begin
    int ed; bit es; longint r; int od;
    od = int'($signed(out_data));
    if (rst) begin
      raw_q.delete();
      acc_m = 0;
      held  = 0;
    end else begin
      chk(in_rdy == (!out_vld || out_rdy), "in_rdy_rule", in_rdy, (!out_vld || out_rdy));
      if (held) begin
        chk(out_vld == 1'b1, "hold_vld", out_vld, 1);
        chk(od == held_data, "hold_data", od, held_data);
        chk(out_sat == held_sat, "hold_sat", out_sat, held_sat);
      end else if (out_vld) begin
        if (raw_q.size() == 0) chk(1'b0, "spurious_out", od, 0);
        else begin
          r = raw_q.pop_front();
          shape(r, bias_prev, shift_prev, relu_prev, ed, es);
          chk(od == ed, "out_data", od, ed);
          chk(out_sat == es, "out_sat", out_sat, es);
          log_q.push_back('{data: od, sat: out_sat, cyc: cyc});
        end
      end
      held      = out_vld && !out_rdy;
      held_data = od;
      held_sat  = out_sat;
      if (in_vld && in_rdy) begin
        acc_m = in_first ? wrap_acc(dot(in_data, in_weight)) : wrap_acc(acc_m + dot(in_data, in_weight));
        if (in_last) raw_q.push_back(acc_m);
      end
    end
    bias_prev  = longint'(signed'(cfg_bias));
    shift_prev = int'(cfg_shift);
    relu_prev  = cfg_relu;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [VW-1:0] fill(input int v);
    logic [VW-1:0] r;
    for (int i = 0; i < N_TAPS; i++) r[i*DATA_W +: DATA_W] = DATA_W'(v);
    return r;
  endfunction

  function automatic logic [VW-1:0] tap0(input int v);
    logic [VW-1:0] r = '0;
    r[DATA_W-1:0] = DATA_W'(v);
    return r;
  endfunction

  function automatic logic [VW-1:0] units(input int k);
    logic [VW-1:0] r = '0;
    for (int i = 0; i < k; i++) r[i*DATA_W +: DATA_W] = DATA_W'(1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input bit f, input bit l, input logic [VW-1:0] d, input logic [VW-1:0] w);
    int n = 0;
    in_vld = 1'b1; in_first = f; in_last = l; in_data = d; in_weight = w;
    @(negedge clk);
    while (!in_rdy && n < 200) begin @(negedge clk); n++; end
    if (!in_rdy) chk(1'b0, "send_timeout", n, 200);
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic wait_log(input int target);
    int n = 0;
    while (log_q.size() < target && n < 200) begin tick(); n++; end
    if (log_q.size() < target) chk(1'b0, "wait_out_timeout", log_q.size(), target);
  endtask

  task automatic drain();
    out_rdy = 1'b1;
    repeat (12) tick();
  endtask

  task automatic set_cfg(input int bias, input int shift, input bit relu);
    cfg_bias = ACC_W'(bias); cfg_shift = SHIFT_W'(shift); cfg_relu = relu;
  endtask

  function automatic int lg_data(input int i);
    if (i < log_q.size()) return log_q[i].data;
    return -9999;
  endfunction

  function automatic int lg_sat(input int i);
    if (i < log_q.size()) return int'(log_q[i].sat);
    return -1;
  endfunction

  function automatic int lg_cyc(input int i);
    if (i < log_q.size()) return log_q[i].cyc;
    return -9999;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  bit rand_done;

  initial begin
    int base, t, d0, n;
    rst = 1'b1; in_vld = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_data = '0; in_weight = '0; out_rdy = 1'b1;
    set_cfg(0, 0, 1'b0);
    repeat (3) tick();
    chk(out_vld == 1'b0, "rst_out_vld", out_vld, 0);
    chk(out_data == '0, "rst_out_data", out_data, 0);
    chk(out_sat == 1'b0, "rst_out_sat", out_sat, 0);
    rst = 1'b0;
    tick();
    chk(in_rdy == 1'b1, "rst_in_rdy", in_rdy, 1);

    // 1: all ones, single beat -> 9 after four cycles
    base = log_q.size(); t = cyc;
    send(1, 1, fill(1), fill(1));
    wait_log(base + 1);
    chk(lg_data(base) == 9, "t1_data", lg_data(base), 9);
    chk(lg_sat(base) == 0, "t1_sat", lg_sat(base), 0);
    chk(lg_cyc(base) - t == 4, "t1_latency", lg_cyc(base) - t, 4);

    // 2: saturation both ways
    base = log_q.size();
    send(1, 1, fill(-128), fill(-128));
    send(1, 1, fill(127), fill(-128));
    wait_log(base + 2);
    chk(lg_data(base) == 127, "t2_pos_data", lg_data(base), 127);
    chk(lg_sat(base) == 1, "t2_pos_sat", lg_sat(base), 1);
    chk(lg_data(base + 1) == -128, "t2_neg_data", lg_data(base + 1), -128);
    chk(lg_sat(base + 1) == 1, "t2_neg_sat", lg_sat(base + 1), 1);
    drain();

    // 3: three-beat frame with bias/shift, then a single-beat frame right behind it
    set_cfg(-5, 2, 1'b0);
    base = log_q.size();
    send(1, 0, tap0(10), tap0(1));
    send(0, 0, tap0(10), tap0(1));
    send(0, 1, tap0(10), tap0(1));
    send(1, 1, units(3), units(3));
    n = 0;
    while (!out_vld && n < 20) begin tick(); n++; end
    set_cfg(0, 0, 1'b0);   // second result loads on the next edge
    wait_log(base + 2);
    chk(lg_data(base) == 6, "t3_frame_a", lg_data(base), 6);
    chk(lg_data(base + 1) == 3, "t3_frame_b", lg_data(base + 1), 3);
    chk(lg_cyc(base + 1) - lg_cyc(base) == 1, "t3_spacing", lg_cyc(base + 1) - lg_cyc(base), 1);
    drain();

    // 4: ReLU on/off
    set_cfg(0, 0, 1'b1);
    base = log_q.size();
    send(1, 1, tap0(-40), tap0(1));
    wait_log(base + 1);
    chk(lg_data(base) == 0, "t4_relu_data", lg_data(base), 0);
    chk(lg_sat(base) == 0, "t4_relu_sat", lg_sat(base), 0);
    drain();
    set_cfg(0, 0, 1'b0);
    base = log_q.size();
    send(1, 1, tap0(-40), tap0(1));
    wait_log(base + 1);
    chk(lg_data(base) == -40, "t4_norelu_data", lg_data(base), -40);
    chk(lg_sat(base) == 0, "t4_norelu_sat", lg_sat(base), 0);
    drain();

    // 5: backpressure while streaming
    base = log_q.size();
    fork
      begin
        for (int k = 0; k < 8; k++) send(1, 1, tap0(k + 1), tap0(5));
      end
      begin
        n = 0;
        while (!out_vld && n < 50) begin tick(); n++; end
        out_rdy = 1'b0;
        d0 = int'($signed(out_data));
        repeat (10) begin
          tick();
          chk(in_rdy == 1'b0, "t5_in_rdy_stall", in_rdy, 0);
          chk(int'($signed(out_data)) == d0, "t5_data_frozen", int'($signed(out_data)), d0);
        end
        out_rdy = 1'b1;
      end
    join
    wait_log(base + 8);
    for (int k = 0; k < 8; k++)
      chk(lg_data(base + k) == 5 * (k + 1), "t5_order", lg_data(base + k), 5 * (k + 1));
    drain();
    chk(log_q.size() == base + 8, "t5_no_dup", log_q.size(), base + 8);

    // 6: reset mid-accumulation with a result stalled on the output
    out_rdy = 1'b0;
    send(1, 1, tap0(7), tap0(1));
    send(1, 0, tap0(3), tap0(1));
    send(0, 0, tap0(3), tap0(1));
    n = 0;
    while (!out_vld && n < 20) begin tick(); n++; end
    chk(out_vld == 1'b1, "t6_pre_vld", out_vld, 1);
    rst = 1'b1;
    #1;
    chk(out_vld == 1'b0, "t6_async_vld", out_vld, 0);
    chk(out_data == '0, "t6_async_data", out_data, 0);
    chk(out_sat == 1'b0, "t6_async_sat", out_sat, 0);
    tick(); tick();
    rst = 1'b0; out_rdy = 1'b1;
    tick();
    chk(in_rdy == 1'b1, "t6_in_rdy", in_rdy, 1);
    base = log_q.size();
    send(0, 1, tap0(4), tap0(1));
    send(1, 1, tap0(4), tap0(1));
    wait_log(base + 2);
    chk(lg_data(base) == 4, "t6_last_only", lg_data(base), 4);
    chk(lg_data(base + 1) == 4, "t6_single", lg_data(base + 1), 4);
    drain();

    // randomized frames, bubbles and backpressure against the model
    set_cfg(int'($urandom_range(0, 2 ** 21)) - 2 ** 20, int'($urandom_range(0, ACC_W - 1)), 1'($urandom));
    tick();
    rand_done = 1'b0;
    fork
      begin
        logic [VW-1:0] d, w;
        for (int b = 0; b < 400; b++) begin
          if ($urandom_range(0, 4) == 0) tick();
          else begin
            for (int i = 0; i < N_TAPS; i++) begin
              d[i*DATA_W +: DATA_W] = DATA_W'($urandom);
              w[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            send(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), d, w);
          end
          if (b == 200) begin
            // change configuration only with the pipe idle
            in_vld = 1'b0;
            while (raw_q.size() != 0 && n < 2000) begin tick(); n++; end
            repeat (6) tick();
            set_cfg(int'($urandom_range(0, 2 ** 21)) - 2 ** 20, int'($urandom_range(0, ACC_W - 1)), 1'($urandom));
            tick();
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          tick();
          out_rdy = ($urandom_range(0, 3) != 0);
        end
        out_rdy = 1'b1;
      end
    join
    drain();
    chk(raw_q.size() == 0, "rand_all_delivered", raw_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
